// File: rtl/multi_xfer_seq_if.sv
// Decode-stage bundle for the multiple-transfer sequencer: instruction, stall
// and kill in; per-cycle transfer descriptor out.
interface multi_xfer_seq_if;
    logic [15:0] IM_d;
    logic        hold;
    logic        flush;
    logic [2:0]  regr;
    logic [2:0]  offset;
    logic        comp;
    logic        comp1;
    logic        xfer_valid;
    logic        busy;

    modport master (
        output IM_d, hold, flush,
        input  regr, offset, comp, comp1, xfer_valid, busy
    );

    modport slave (
        input  IM_d, hold, flush,
        output regr, offset, comp, comp1, xfer_valid, busy
    );
endinterface

// File: rtl/multi_xfer_seq.sv
// Sequencer for LM/SM (masked) and LA/SA (all eight registers) multi-cycle
// transfers; the first transfer is decoded combinationally from IM_d.
module multi_xfer_seq (
    input  logic             clk,
    input  logic             reset,
    multi_xfer_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_ALL   = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] mask_q, mask_next;
    logic [2:0] cnt_q, cnt_next;

    logic [3:0] opcode;
    logic       op_multi;
    logic       op_all;
    logic [7:0] wm;
    logic [7:0] wm_rest;
    logic [7:0] lsb_onehot;
    logic [2:0] lsb_idx;

    logic [2:0] regr_c;
    logic [2:0] offset_c;
    logic       comp_c;
    logic       comp1_c;
    logic       xfer_valid_c;
    logic       busy_c;

    // Bits 11:8 of the instruction carry nothing this block needs.
    logic       unused_bits;
    assign unused_bits = ^bus.IM_d[11:8];

    assign opcode   = bus.IM_d[15:12];
    assign op_multi = (opcode[3:1] == 3'b110);
    assign op_all   = (opcode[3:1] == 3'b111);

    assign wm         = (state_reg == ST_IDLE) ? bus.IM_d[7:0] : mask_q;
    assign wm_rest    = wm & (wm - 8'd1);
    assign lsb_onehot = wm & ~(wm - 8'd1);

    // Encode the isolated lowest bit: output bit gi is set when the chosen
    // position has bit gi set in its index.
    function automatic logic [7:0] enc_mask(input int b);
        logic [7:0] m;
        m = '0;
        for (int p = 0; p < 8; p++) begin
            m[p] = p[b];
        end
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_enc
            assign lsb_idx[gi] = |(lsb_onehot & enc_mask(gi));
        end
    endgenerate

    always_comb begin
        regr_c       = 3'd0;
        offset_c     = 3'd0;
        comp_c       = 1'b1;
        comp1_c      = 1'b1;
        xfer_valid_c = 1'b0;
        busy_c       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (op_multi) begin
                    regr_c       = lsb_idx;
                    comp_c       = (wm_rest == 8'd0);
                    xfer_valid_c = |wm;
                end else if (op_all) begin
                    regr_c       = 3'd0;
                    comp1_c      = (regr_c == 3'd7);
                    xfer_valid_c = 1'b1;
                end
            end
            ST_MULTI: begin
                regr_c       = lsb_idx;
                offset_c     = cnt_q;
                comp_c       = (wm_rest == 8'd0);
                xfer_valid_c = |wm;
                busy_c       = 1'b1;
            end
            ST_ALL: begin
                regr_c       = cnt_q;
                offset_c     = cnt_q;
                comp1_c      = (cnt_q == 3'd7);
                xfer_valid_c = 1'b1;
                busy_c       = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    // Flush wins over hold; once a sequence is running the opcode is ignored.
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_q;
        cnt_next   = cnt_q;
        if (bus.flush) begin
            state_next = ST_IDLE;
            mask_next  = 8'd0;
            cnt_next   = 3'd0;
        end else if (!bus.hold) begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_multi && !comp_c) begin
                        state_next = ST_MULTI;
                        mask_next  = wm_rest;
                        cnt_next   = 3'd1;
                    end else if (op_all) begin
                        state_next = ST_ALL;
                        mask_next  = 8'd0;
                        cnt_next   = 3'd1;
                    end
                end
                ST_MULTI: begin
                    if (comp_c) begin
                        state_next = ST_IDLE;
                        mask_next  = 8'd0;
                        cnt_next   = 3'd0;
                    end else begin
                        mask_next = wm_rest;
                        cnt_next  = cnt_q + 3'd1;
                    end
                end
                ST_ALL: begin
                    if (cnt_q == 3'd7) begin
                        state_next = ST_IDLE;
                        cnt_next   = 3'd0;
                    end else begin
                        cnt_next = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    mask_next  = 8'd0;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            mask_q    <= 8'd0;
            cnt_q     <= 3'd0;
        end else begin
            state_reg <= state_next;
            mask_q    <= mask_next;
            cnt_q     <= cnt_next;
        end
    end

    assign bus.regr       = regr_c;
    assign bus.offset     = offset_c;
    assign bus.comp       = comp_c;
    assign bus.comp1      = comp1_c;
    assign bus.xfer_valid = xfer_valid_c;
    assign bus.busy       = busy_c;
endmodule

// File: tb/tb_multi_xfer_seq.sv
// Self-checking bench for multi_xfer_seq: a transfer-list model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_multi_xfer_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_xfer_seq_if bus();
    multi_xfer_seq dut (.clk(clk), .reset(reset), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is a list of register indices (set bits of the
    // mask ascending, or 0..7); m_pos is the position in that list.
    bit         m_active = 1'b0;
    bit         m_all    = 1'b0;
    logic [7:0] m_mask   = 8'd0;
    int         m_pos    = 0;

    function automatic int nth_set(input logic [7:0] m, input int k);
        int seen;
        seen = 0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) begin
                if (seen == k) return b;
                seen++;
            end
        end
        return 0;
    endfunction

    function automatic bit is_lmsm(input logic [15:0] im);
        return (im[15:12] == 4'hC) || (im[15:12] == 4'hD);
    endfunction

    function automatic bit is_lasa(input logic [15:0] im);
        return (im[15:12] == 4'hE) || (im[15:12] == 4'hF);
    endfunction

    logic [2:0] e_regr, e_offset;
    logic       e_comp, e_comp1, e_xv, e_busy;

    always_comb begin
        logic [7:0] msk;
        bit         k_multi, k_all;
        int         pos, len;
        msk = m_active ? m_mask : bus.IM_d[7:0];
        k_multi = m_active ? !m_all : is_lmsm(bus.IM_d);
        k_all   = m_active ?  m_all : is_lasa(bus.IM_d);
        pos = m_active ? m_pos : 0;
        len = k_all ? 8 : $countones(msk);
        e_regr = 3'd0; e_comp = 1'b1; e_comp1 = 1'b1; e_xv = 1'b0;
        if (k_multi) begin
            e_regr = (len != 0) ? 3'(nth_set(msk, pos)) : 3'd0;
            e_comp = (len == 0) || (pos == len - 1);
            e_xv   = (len != 0);
        end else if (k_all) begin
            e_regr  = 3'(pos);
            e_comp1 = (pos == 7);
            e_xv    = 1'b1;
        end
        e_offset = 3'(pos);
        e_busy   = m_active;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
        end else if (bus.flush) begin
            m_active <= 1'b0;
        end else if (!bus.hold) begin
            if (!m_active) begin
                if (is_lasa(bus.IM_d) ||
                    (is_lmsm(bus.IM_d) && $countones(bus.IM_d[7:0]) > 1)) begin
                    m_active <= 1'b1;
                    m_all    <= is_lasa(bus.IM_d);
                    m_mask   <= bus.IM_d[7:0];
                    m_pos    <= 1;
                end
            end else if (m_pos == (m_all ? 8 : $countones(m_mask)) - 1) begin
                m_active <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_regr",   16'(bus.regr),       16'(e_regr));
        chk("m_offset", 16'(bus.offset),     16'(e_offset));
        chk("m_comp",   16'(bus.comp),       16'(e_comp));
        chk("m_comp1",  16'(bus.comp1),      16'(e_comp1));
        chk("m_xv",     16'(bus.xfer_valid), 16'(e_xv));
        chk("m_busy",   16'(bus.busy),       16'(e_busy));
    end

    task automatic cyc(input logic [15:0] im, input logic h, input logic f);
        @(posedge clk);
        #1;
        bus.IM_d  = im;
        bus.hold  = h;
        bus.flush = f;
        @(negedge clk);
    endtask

    initial begin
        int a5_regr [4];
        a5_regr = '{0, 2, 5, 7};
        reset     = 1'b0;
        bus.IM_d  = 16'h6000;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("rst_regr",  16'(bus.regr),       16'd0);
        chk("rst_off",   16'(bus.offset),     16'd0);
        chk("rst_comp",  16'(bus.comp),       16'd1);
        chk("rst_comp1", 16'(bus.comp1),      16'd1);
        chk("rst_xv",    16'(bus.xfer_valid), 16'd0);
        chk("rst_busy",  16'(bus.busy),       16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // LM 0xA5 for four cycles
        for (int i = 0; i < 4; i++) begin
            cyc(16'hC0A5, 1'b0, 1'b0);
            chk("lm_a5_regr", 16'(bus.regr),   16'(a5_regr[i]));
            chk("lm_a5_off",  16'(bus.offset), 16'(i));
            chk("lm_a5_comp", 16'(bus.comp),   16'(i == 3));
            chk("lm_a5_busy", 16'(bus.busy),   16'(i != 0));
        end
        cyc(16'h6000, 1'b0, 1'b0);
        chk("lm_a5_done", 16'(bus.busy), 16'd0);

        // SM empty mask, SM single bit 7
        cyc(16'hD000, 1'b0, 1'b0);
        chk("sm_00_comp", 16'(bus.comp),       16'd1);
        chk("sm_00_xv",   16'(bus.xfer_valid), 16'd0);
        chk("sm_00_busy", 16'(bus.busy),       16'd0);
        cyc(16'h6000, 1'b0, 1'b0);
        chk("sm_00_after", 16'(bus.busy), 16'd0);
        cyc(16'hD080, 1'b0, 1'b0);
        chk("sm_80_regr", 16'(bus.regr), 16'd7);
        chk("sm_80_comp", 16'(bus.comp), 16'd1);
        cyc(16'h6000, 1'b0, 1'b0);
        chk("sm_80_after", 16'(bus.busy), 16'd0);

        // LA for eight cycles
        for (int i = 0; i < 8; i++) begin
            cyc(16'hE000, 1'b0, 1'b0);
            chk("la_regr",  16'(bus.regr),  16'(i));
            chk("la_comp1", 16'(bus.comp1), 16'(i == 7));
            chk("la_comp",  16'(bus.comp),  16'd1);
        end
        cyc(16'h6000, 1'b0, 1'b0);
        chk("la_done", 16'(bus.busy), 16'd0);

        // LM 0xFF with hold in cycles 3..5
        for (int c = 1; c <= 11; c++) begin
            cyc(16'hC0FF, (c >= 3 && c <= 5), 1'b0);
            if (c >= 3 && c <= 5) begin
                chk("hold_regr", 16'(bus.regr),   16'd2);
                chk("hold_off",  16'(bus.offset), 16'd2);
            end
            if (c == 11) begin
                chk("hold_end_regr", 16'(bus.regr), 16'd7);
                chk("hold_end_comp", 16'(bus.comp), 16'd1);
            end
        end
        cyc(16'h6000, 1'b0, 1'b0);
        chk("hold_done", 16'(bus.busy), 16'd0);

        // SA flushed in cycle 4
        for (int c = 1; c <= 5; c++) begin
            cyc((c == 5) ? 16'h6000 : 16'hF000, 1'b0, (c == 4));
            if (c == 4) chk("sa_fl_regr", 16'(bus.regr), 16'd3);
            if (c == 5) chk("sa_fl_busy", 16'(bus.busy), 16'd0);
        end

        // Reset in cycle 3 of LM 0xFF
        cyc(16'hC0FF, 1'b0, 1'b0);
        cyc(16'hC0FF, 1'b0, 1'b0);
        chk("rs_c2_regr", 16'(bus.regr), 16'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rs_busy_now", 16'(bus.busy), 16'd0);
        chk("rs_regr_now", 16'(bus.regr), 16'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rs_rel_regr", 16'(bus.regr), 16'd0);
        chk("rs_rel_busy", 16'(bus.busy), 16'd0);
        cyc(16'hC0FF, 1'b0, 1'b0);
        chk("rs_next_regr", 16'(bus.regr), 16'd1);
        repeat (8) cyc(16'h6000, 1'b0, 1'b0);
        chk("rs_done", 16'(bus.busy), 16'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  op;
            logic [7:0]  msk;
            logic [15:0] im;
            case ($urandom_range(0, 5))
                0: op = 4'hC;
                1: op = 4'hD;
                2: op = 4'hE;
                3: op = 4'hF;
                4: op = 4'h6;
                default: op = 4'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: msk = 8'h00;
                1: msk = 8'h01 << $urandom_range(0, 7);
                default: msk = 8'($urandom);
            endcase
            im = {op, 4'($urandom), msk};
            @(posedge clk);
            #1;
            bus.IM_d  = im;
            bus.hold  = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 49) != 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        repeat (10) cyc(16'h6000, 1'b0, 1'b0);
        chk("final_idle", 16'(bus.busy), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_xfer_seq.md
MULTI_XFER_SEQ -- requirements
Module: multi_xfer_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have: IM_d  input  16  instruction in decode; opcode IM_d[15:12], register mask IM_d[7:0].
REQ-004 The block SHALL have: hold  input  1  pipeline stall; freezes all state.
REQ-005 The block SHALL have: flush  input  1  kill the instruction in decode; aborts any sequence.
REQ-006 The block SHALL have: regr  output  3  register index for the current transfer.
REQ-007 The block SHALL have: offset  output  3  transfer ordinal (0 = first) for address generation.
REQ-008 The block SHALL have: comp  output  1  last transfer of an LM/SM (gates pcwrite).
REQ-009 The block SHALL have: comp1  output  1  last transfer of an LA/SA (gates pcwrite).
REQ-010 The block SHALL have: xfer_valid  output  1  the current cycle performs a register/memory transfer.
REQ-011 The block SHALL have: busy  output  1  state is not IDLE.

Function
REQ-012 States SHALL be IDLE, MULTI (LM 1100 / SM 1101) and ALL (LA 1110 / SA 1111); internal registers are state, mask_q[7:0] and cnt_q[2:0].
REQ-013 Working mask wm SHALL be IM_d[7:0] in IDLE and mask_q in MULTI.
REQ-014 regr SHALL be the index of the lowest set bit of wm in IDLE with LM/SM opcode, or in MULTI; it SHALL be 0 when wm = 0.
REQ-015 comp SHALL be 1 when wm with its lowest set bit cleared is zero; it SHALL also be 1 in IDLE for any non-LM/SM opcode.
REQ-016 In ALL, and in IDLE with LA/SA opcode, regr SHALL be cnt_q (0 in IDLE), and comp1 SHALL be 1 exactly when regr = 7.
REQ-017 comp1 SHALL be 1 in IDLE for any non-LA/SA opcode and in MULTI.
REQ-018 offset SHALL be cnt_q in MULTI/ALL and 0 in IDLE.
REQ-019 xfer_valid SHALL be 1 for LM/SM when wm is nonzero and for every LA/SA cycle; otherwise it SHALL be 0.
REQ-020 All outputs SHALL be combinational from state, the registers and IM_d, with zero latency: the first transfer occurs in the cycle the instruction enters decode.
REQ-021 On a clock edge with hold=0 and flush=0, the block SHALL transition IDLE->MULTI when the opcode is LM/SM and comp=0, loading mask_q = wm with its lowest set bit cleared and cnt_q = 1.
REQ-022 On the same edge conditions, the block SHALL transition IDLE->ALL when the opcode is LA/SA, loading cnt_q = 1.
REQ-023 In MULTI, when comp=0 the block SHALL clear the lowest set bit of mask_q and increment cnt_q; when comp=1 it SHALL return to IDLE and clear mask_q and cnt_q.
REQ-024 In ALL, the block SHALL increment cnt_q; when cnt_q = 7 it SHALL return to IDLE with cnt_q = 0.
REQ-025 In MULTI/ALL, IM_d[15:12] SHALL be ignored for transitions; the sequence completes on the captured mask/count.
REQ-026 An empty LM/SM mask SHALL give comp=1 and xfer_valid=0 in the first cycle, and the block SHALL stay in IDLE.
REQ-027 hold=1 SHALL freeze state, mask_q and cnt_q; outputs SHALL remain stable while IM_d is stable.
REQ-028 flush=1 SHALL force IDLE, mask_q = 0 and cnt_q = 0 on the next edge; flush SHALL have priority over hold.
REQ-029 cnt_q SHALL never wrap: at most 8 transfers per instruction.

Reset
REQ-030 While reset = 0, the block SHALL asynchronously force state = IDLE, mask_q = 0 and cnt_q = 0.
REQ-031 During reset, outputs SHALL follow IDLE decode of IM_d; with IM_d = 16'h6000 (NOP): regr=0, offset=0, comp=1, comp1=1, xfer_valid=0, busy=0.
REQ-032 Reset asserted mid-sequence SHALL abort it immediately; the first edge after release SHALL treat IM_d as a new instruction.

Verification
REQ-033 The bench SHALL cover: LM, mask 8'hA5, held 4 cycles -> regr 0,2,5,7; offset 0,1,2,3; comp=1 only in cycle 4; busy 0,1,1,1; then IDLE.
REQ-034 The bench SHALL cover: SM, mask 8'h00 -> comp=1, xfer_valid=0 and busy=0 in cycle 1; no state change.
REQ-035 The bench SHALL cover: SM, mask 8'h80 -> regr=7, comp=1 in cycle 1; stays IDLE.
REQ-036 The bench SHALL cover: LA held 8 cycles -> regr 0..7; comp1=1 only at regr=7; comp=1 throughout; then IDLE.
REQ-037 The bench SHALL cover: LM 8'hFF with hold=1 in cycles 3-5 -> regr stays 2 and offset stays 2 through cycle 5; completes at cycle 11 with regr=7, comp=1.
REQ-038 The bench SHALL cover: SA with flush at cycle 4 -> IDLE and busy=0 in cycle 5; separately, reset=0 in cycle 3 of LM 8'hFF -> busy=0 immediately, and regr restarts at 0 after release.
